// File: rtl/ts_capture_fifo.sv
// rtl/ts_capture_fifo.sv - multi-channel timestamp capture queue read over a CE_N/SCLK/SDO slave port.
// Optional CAPT_DEGLITCH_EN: captures must hold high 4 synchronised samples before being accepted.
module ts_capture_fifo #(
  parameter int CNT_W = 16,
  parameter int NCH   = 4,
  parameter int DEPTH = 8
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           CNT_CLR,
  input  logic [NCH-1:0] CAPT,
  input  logic           SCLK,
  input  logic           CE_N,
  output logic           SDO,
  output logic           INT,
  output logic           OVF
);
  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int EW   = 1 + CH_W + CNT_W;
  localparam int FW   = 1 + EW;
  localparam int AW   = $clog2(DEPTH);
  localparam int BC_W = $clog2(FW + 1);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [BC_W-1:0] FW_C = BC_W'(FW);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT} state_t;

  logic [CNT_W-1:0] cnt;
  logic [NCH-1:0]   capt_s1, capt_s2, capt_rise;
  logic [NCH-1:0]   pend;
  logic [CNT_W-1:0] cap_ts [NCH];
  logic             push_any, push, pop, drop, full, empty;
  logic [CH_W-1:0]  push_ch;
  logic [EW-1:0]    mem [DEPTH];
  logic [EW-1:0]    head;
  logic [AW:0]      wr_ptr, rd_ptr, count;
  logic             ce_s1, ce_s2, ce_d, sclk_s1, sclk_s2, sclk_d;
  logic             ce_fall, ce_rise, sclk_fall;
  state_t           state, state_nxt;
  logic [FW-1:0]    sh, sh_nxt;
  logic [BC_W-1:0]  bcnt, bcnt_nxt;
  logic             fvalid, fvalid_nxt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)          cnt <= '0;
    else if (CNT_CLR) cnt <= '0;
    else              cnt <= cnt + CNT_W'(1);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      capt_s1 <= '0;
      capt_s2 <= '0;
    end else begin
      capt_s1 <= CAPT;
      capt_s2 <= capt_s1;
    end
  end

`ifdef CAPT_DEGLITCH_EN
  logic [1:0]     qual [NCH];
  logic [NCH-1:0] capt_filt;

  // qual counts consecutive high samples; the rise fires on the 4th one
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      capt_filt <= '0;
      capt_rise <= '0;
      for (int i = 0; i < NCH; i++) qual[i] <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (!capt_s2[i]) begin
          qual[i]      <= '0;
          capt_filt[i] <= 1'b0;
          capt_rise[i] <= 1'b0;
        end else if (qual[i] != 2'd3) begin
          qual[i]      <= qual[i] + 2'd1;
          capt_rise[i] <= 1'b0;
        end else begin
          capt_filt[i] <= 1'b1;
          capt_rise[i] <= !capt_filt[i];
        end
      end
    end
  end
`else
  logic [NCH-1:0] capt_d;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      capt_d    <= '0;
      capt_rise <= '0;
    end else begin
      capt_d    <= capt_s2;
      capt_rise <= capt_s2 & ~capt_d;
    end
  end
`endif

  always_comb begin
    push_any = 1'b0;
    push_ch  = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (pend[i]) begin
        push_any = 1'b1;
        push_ch  = CH_W'(i);
      end
    end
  end

  assign push = push_any && (!full || pop);
  assign drop = |(capt_rise & pend);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pend <= '0;
      for (int i = 0; i < NCH; i++) cap_ts[i] <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (push && push_ch == CH_W'(i)) pend[i] <= 1'b0;
        if (capt_rise[i] && !pend[i]) begin
          pend[i]   <= 1'b1;
          cap_ts[i] <= cnt;
        end
      end
    end
  end

  assign count = wr_ptr - rd_ptr;
  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {OVF, push_ch, cap_ts[push_ch]};
  end

  // A drop in the same cycle as an OVF-clearing pop keeps the flag set
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      INT    <= 1'b0;
      OVF    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      INT <= !empty;
      if (drop)                   OVF <= 1'b1;
      else if (pop && head[EW-1]) OVF <= 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      {ce_s1, ce_s2, ce_d}       <= '0;
      {sclk_s1, sclk_s2, sclk_d} <= '0;
    end else begin
      ce_s1   <= CE_N;
      ce_s2   <= ce_s1;
      ce_d    <= ce_s2;
      sclk_s1 <= SCLK;
      sclk_s2 <= sclk_s1;
      sclk_d  <= sclk_s2;
    end
  end

  assign ce_fall   = ce_d & ~ce_s2;
  assign ce_rise   = ~ce_d & ce_s2;
  assign sclk_fall = sclk_d & ~sclk_s2;

  always_comb begin
    state_nxt  = state;
    sh_nxt     = sh;
    bcnt_nxt   = bcnt;
    fvalid_nxt = fvalid;
    pop        = 1'b0;
    case (state)
      S_IDLE: if (ce_fall) state_nxt = S_LOAD;
      S_LOAD: begin
        fvalid_nxt = !empty;
        sh_nxt     = empty ? '0 : {1'b1, head};
        bcnt_nxt   = '0;
        state_nxt  = ce_rise ? S_IDLE : S_SHIFT;
      end
      S_SHIFT: begin
        if (ce_rise) begin
          state_nxt = S_IDLE;
          pop       = fvalid && (bcnt == FW_C);
        end else if (sclk_fall) begin
          sh_nxt = {sh[FW-2:0], 1'b0};
          if (bcnt != FW_C) bcnt_nxt = bcnt + BC_W'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= S_IDLE;
      sh     <= '0;
      bcnt   <= '0;
      fvalid <= 1'b0;
    end else begin
      state  <= state_nxt;
      sh     <= sh_nxt;
      bcnt   <= bcnt_nxt;
      fvalid <= fvalid_nxt;
    end
  end

  assign SDO = (state == S_SHIFT) && !ce_s2 && sh[FW-1];

endmodule

// File: tb/tb_ts_capture_fifo.sv
// tb/tb_ts_capture_fifo.sv - self-checking bench for ts_capture_fifo (vector table, corner sequences, random vs queue model).
module tb_ts_capture_fifo;
  localparam int CNT_W = 16;
  localparam int NCH   = 4;
  localparam int DEPTH = 8;
  localparam int CH_W  = 2;
  localparam int FW    = 2 + CH_W + CNT_W;
`ifdef CAPT_DEGLITCH_EN
  localparam int LAT = 6;
  localparam int W2N = 0;
  localparam int W3N = 0;
`else
  localparam int LAT = 3;
  localparam int W2N = 1;
  localparam int W3N = 1;
`endif

  logic           CLK = 1'b0;
  logic           RST = 1'b1;
  logic           CNT_CLR = 1'b0;
  logic [NCH-1:0] CAPT = '0;
  logic           SCLK = 1'b0;
  logic           CE_N = 1'b1;
  logic           SDO, INT, OVF;

  ts_capture_fifo #(.CNT_W(CNT_W), .NCH(NCH), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST), .CNT_CLR(CNT_CLR), .CAPT(CAPT),
    .SCLK(SCLK), .CE_N(CE_N), .SDO(SDO), .INT(INT), .OVF(OVF)
  );

  always #5 CLK = ~CLK;

  // Reference free-running counter: value present just before a CLK edge
  logic [CNT_W-1:0] ref_cnt;
  always @(posedge CLK or posedge RST) begin
    if (RST)          ref_cnt <= '0;
    else if (CNT_CLR) ref_cnt <= '0;
    else              ref_cnt <= ref_cnt + 1'b1;
  end

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] q[$];

  typedef struct {
    int             pre;
    logic [NCH-1:0] mask;
    int             width;
    int             exp_n;
    logic [CNT_W-1:0] exp_ts;
  } vec_t;
  vec_t tbl[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mk(input logic v, input logic o, input int ch, input logic [CNT_W-1:0] ts);
    logic [CH_W-1:0] c;
    c = CH_W'(ch);
    return {44'b0, v, o, c, ts};
  endfunction

  task automatic read_frame(input int n, output logic [63:0] v);
    CE_N = 1'b0;
    repeat (6) @(negedge CLK);
    v = '0;
    for (int i = 0; i < n; i++) begin
      SCLK = 1'b1;
      repeat (4) @(negedge CLK);
      v = {v[62:0], SDO};
      SCLK = 1'b0;
      repeat (4) @(negedge CLK);
    end
    CE_N = 1'b1;
    repeat (6) @(negedge CLK);
  endtask

  task automatic capture(input logic [NCH-1:0] m, input int w, output logic [CNT_W-1:0] ts);
    ts   = ref_cnt + CNT_W'(LAT);
    CAPT = m;
    repeat (w) @(negedge CLK);
    CAPT = '0;
  endtask

  task automatic model_read();
    logic [63:0] exp, v;
    int n;
    exp = q.pop_front();
    if ($urandom_range(0, 3) == 0) begin
      n = $urandom_range(1, FW - 1);
      read_frame(n, v);
      check("rnd_abort_prefix", v, exp >> (FW - n));
    end
    read_frame(FW, v);
    check("rnd_frame", v, exp);
    check("rnd_int", INT, q.size() != 0);
  endtask

  initial begin
    logic [63:0] v;
    logic [CNT_W-1:0] ts, tsa, tsb, wts;
    logic [CNT_W-1:0] ts0 [8];
    int k;

    tbl[0] = '{10, 4'b0001, 2, W2N, 16'(10 + LAT)};
    tbl[1] = '{5,  4'b1010, 4, 2,   16'(5 + LAT)};
    tbl[2] = '{0,  4'b0100, 4, 1,   16'(LAT)};
    tbl[3] = '{20, 4'b1111, 5, 4,   16'(20 + LAT)};
    tbl[4] = '{3,  4'b1000, 3, W3N, 16'(3 + LAT)};

    repeat (3) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    check("reset_sdo", SDO, 0);
    check("reset_int", INT, 0);
    check("reset_ovf", OVF, 0);

    read_frame(FW + 2, v);
    check("empty_frame", v, 0);
    check("empty_int", INT, 0);

    for (int t = 0; t < 5; t++) begin
      CNT_CLR = 1'b1;
      @(negedge CLK);
      CNT_CLR = 1'b0;
      repeat (tbl[t].pre) @(negedge CLK);
      capture(tbl[t].mask, tbl[t].width, ts);
      repeat (12) @(negedge CLK);
      check("vec_int_pending", INT, tbl[t].exp_n != 0);
      if (tbl[t].exp_n == 0) begin
        read_frame(FW, v);
        check("vec_no_entry", v, 0);
      end else begin
        k = 0;
        for (int c = 0; c < NCH; c++) begin
          if (tbl[t].mask[c]) begin
            read_frame(FW, v);
            check("vec_frame", v, mk(1'b1, 1'b0, c, tbl[t].exp_ts));
            k++;
            check("vec_int_after", INT, k < tbl[t].exp_n);
          end
        end
      end
    end

    capture(4'b0100, 4, ts);
    repeat (12) @(negedge CLK);
    read_frame(2, v);
    check("abort_prefix", v, mk(1'b1, 1'b0, 2, ts) >> (FW - 2));
    check("abort_int_kept", INT, 1);
    read_frame(FW + 2, v);
    check("abort_resend", v, mk(1'b1, 1'b0, 2, ts) << 2);
    check("abort_int_done", INT, 0);

    capture(4'b0111, 4, ts);
    repeat (12) @(negedge CLK);
    check("rst_pre_int", INT, 1);
    CE_N = 1'b0;
    repeat (6) @(negedge CLK);
    for (int i = 0; i < 5; i++) begin
      SCLK = 1'b1;
      repeat (4) @(negedge CLK);
      SCLK = 1'b0;
      repeat (4) @(negedge CLK);
    end
    RST = 1'b1;
    @(negedge CLK);
    check("rst_sdo", SDO, 0);
    check("rst_int", INT, 0);
    check("rst_ovf", OVF, 0);
    @(negedge CLK);
    RST  = 1'b0;
    CE_N = 1'b1;
    repeat (6) @(negedge CLK);
    read_frame(FW, v);
    check("rst_frame_invalid", v, 0);
    check("rst_int_after", INT, 0);

    for (int i = 0; i < 8; i++) begin
      capture(4'b0001, 4, ts);
      ts0[i] = ts;
      repeat (10) @(negedge CLK);
    end
    check("full_int", INT, 1);
    check("full_ovf_clear", OVF, 0);
    capture(4'b0100, 4, tsa);
    repeat (10) @(negedge CLK);
    check("full_pending_no_ovf", OVF, 0);
    capture(4'b0100, 4, tsb);
    repeat (10) @(negedge CLK);
    check("drop_sets_ovf", OVF, 1);
    for (int i = 0; i < 8; i++) begin
      read_frame(FW, v);
      check("full_drain", v, mk(1'b1, 1'b0, 0, ts0[i]));
    end
    check("ovf_held", OVF, 1);
    check("ninth_int", INT, 1);
    read_frame(FW, v);
    check("ninth_frame", v, mk(1'b1, 1'b1, 2, tsa));
    check("ovf_cleared", OVF, 0);
    check("ninth_int_done", INT, 0);

    for (int b = 0; b < 20; b++) begin
      logic [NCH-1:0] m;
      while (q.size() + NCH > DEPTH) model_read();
      m = NCH'($urandom_range(1, (1 << NCH) - 1));
      capture(m, $urandom_range(4, 6), ts);
      for (int c = 0; c < NCH; c++) if (m[c]) q.push_back(mk(1'b1, 1'b0, c, ts));
      repeat (12) @(negedge CLK);
      k = $urandom_range(0, q.size());
      for (int r = 0; r < k; r++) model_read();
    end
    while (q.size() > 0) model_read();
    check("rnd_ovf", OVF, 0);

    k = 0;
    while (ref_cnt != 16'hFFFE && k < 70000) begin
      @(negedge CLK);
      k++;
    end
    check("wrap_reached", ref_cnt, 16'hFFFE);
    wts = 16'hFFFE + 16'(LAT);
    capture(4'b0010, 4, ts);
    repeat (12) @(negedge CLK);
    read_frame(FW, v);
    check("wrap_frame", v, mk(1'b1, 1'b0, 1, wts));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end
endmodule
